// File: rtl/latency_ram.sv
// Word-addressed RAM model that answers the ram request interface after a
// programmable number of BUSY cycles, reporting FREE/BUSY/ACCESS/ERROR.
module latency_ram #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAT_C = CW'(LAT);

    // ramstate_t encoding
    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic          lat_vld_q, lat_vld_d;
    logic [31:0]   lat_addr_q, lat_addr_d;
    logic          lat_op_q, lat_op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem_q [DEPTH];

    logic          req, bad, match, mem_we;
    logic [AW-1:0] idx;

    assign req   = ramREN | ramWEN;
    assign bad   = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00)
                 | (ramaddr[31:2] >= 30'(DEPTH));
    assign idx   = ramaddr[AW+1:2];
    assign match = lat_vld_q & (ramaddr == lat_addr_q) & (ramWEN == lat_op_q);

    // Transaction tracking registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_vld_q  <= 1'b0;
            lat_addr_q <= '0;
            lat_op_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            lat_vld_q  <= lat_vld_d;
            lat_addr_q <= lat_addr_d;
            lat_op_q   <= lat_op_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage array; cleared on reset so an interrupted write leaves no trace
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= ramstore;
        end
    end

    // Next-state: a request that does not match the latched one restarts the count
    always_comb begin
        lat_vld_d  = lat_vld_q;
        lat_addr_d = lat_addr_q;
        lat_op_d   = lat_op_q;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;
        if (!req || bad) begin
            lat_vld_d = 1'b0;
            cnt_d     = '0;
        end else if (!match) begin
            lat_addr_d = ramaddr;
            lat_op_d   = ramWEN;
            lat_vld_d  = 1'b1;
            cnt_d      = CW'(1);
        end else if (cnt_q < LAT_C) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            mem_we    = lat_op_q;
            lat_vld_d = 1'b0;
            cnt_d     = '0;
        end
    end

    // Response outputs
    always_comb begin
        ramstate = ST_BUSY;
        ramload  = '0;
        if (!req) begin
            ramstate = ST_FREE;
        end else if (bad) begin
            ramstate = ST_ERROR;
        end else if (match && (cnt_q == LAT_C)) begin
            ramstate = ST_ACCESS;
        end
        if ((ramstate == ST_ACCESS) && !lat_op_q) begin
            ramload = mem_q[idx];
        end
    end

endmodule

// File: tb/tb_latency_ram.sv
// Scoreboard bench for latency_ram: a LAT=2 instance for the main tests and a
// LAT=1 instance for the back-to-back stream.
module tb_latency_ram;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        sel;
    logic        ren_i, wen_i;
    logic [31:0] addr_i, store_i;

    logic        ren_a, wen_a, ren_b, wen_b;
    logic [31:0] load_a, load_b, load_obs;
    logic [1:0]  st_a, st_b, st_obs;

    logic [31:0] model [256];
    logic [31:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 CLK = ~CLK;

    assign ren_a    = ren_i & ~sel;
    assign wen_a    = wen_i & ~sel;
    assign ren_b    = ren_i & sel;
    assign wen_b    = wen_i & sel;
    assign st_obs   = sel ? st_b : st_a;
    assign load_obs = sel ? load_b : load_a;

    latency_ram #(.LAT(2), .DEPTH(256)) dut_a (
        .CLK(CLK), .nRST(nRST), .ramREN(ren_a), .ramWEN(wen_a),
        .ramaddr(addr_i), .ramstore(store_i), .ramload(load_a), .ramstate(st_a)
    );

    latency_ram #(.LAT(1), .DEPTH(256)) dut_b (
        .CLK(CLK), .nRST(nRST), .ramREN(ren_b), .ramWEN(wen_b),
        .ramaddr(addr_i), .ramstore(store_i), .ramload(load_b), .ramstate(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // Drop the request for one cycle and expect FREE
    task automatic idle(input string tag);
        ren_i = 1'b0;
        wen_i = 1'b0;
        @(negedge CLK);
        chk({tag, "_free"}, 32'(st_obs), 32'(ST_FREE));
        chk({tag, "_load0"}, load_obs, 32'h0);
        @(posedge CLK); #1;
    endtask

    // Hold one request for lat+1 cycles; the request is left asserted on return
    task automatic run_txn(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] data, input int lat, input string tag);
        logic       bad;
        logic [1:0] exp_st;
        bad = (ren & wen) | (addr[1:0] != 2'b00) | (addr[31:2] >= 30'd256);
        if (ren && !wen && !bad) exp_q.push_back(model[addr[9:2]]);
        ren_i   = ren;
        wen_i   = wen;
        addr_i  = addr;
        store_i = data;
        for (int c = 0; c <= lat; c++) begin
            @(negedge CLK);
            exp_st = bad ? ST_ERROR : ((c == lat) ? ST_ACCESS : ST_BUSY);
            chk({tag, "_st"}, 32'(st_obs), 32'(exp_st));
            if (st_obs == ST_ACCESS && ren && !wen) begin
                if (exp_q.size() > 0) chk({tag, "_load"}, load_obs, exp_q.pop_front());
                else chk({tag, "_extra_access"}, 32'(exp_q.size()), 32'd1);
            end else begin
                chk({tag, "_load0"}, load_obs, 32'h0);
            end
            if (!bad && wen && c == lat) model[addr[9:2]] = data;
            @(posedge CLK); #1;
        end
        if (ren && !wen && !bad) chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nRST    = 1'b0;
        sel     = 1'b0;
        ren_i   = 1'b0;
        wen_i   = 1'b0;
        addr_i  = 32'h0;
        store_i = 32'h0;
        clear_model();
        #12 nRST = 1'b1;
        @(posedge CLK); #1;

        // 1: idle, then a held read re-enters BUSY after ACCESS
        idle("t1_idle");
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 2, "t1_rd");
        @(negedge CLK);
        chk("t1_rehold", 32'(st_obs), 32'(ST_BUSY));
        @(posedge CLK); #1;
        idle("t1_end");

        // 2: write then read back; neighbour word stays zero
        run_txn(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 2, "t2_wr");
        idle("t2_gap");
        run_txn(1'b1, 1'b0, 32'h20, 32'h0, 2, "t2_rd20");
        run_txn(1'b1, 1'b0, 32'h24, 32'h0, 2, "t2_rd24");
        idle("t2_end");

        // 3: address switch mid-transaction restarts the latency
        run_txn(1'b0, 1'b1, 32'h44, 32'h12345678, 2, "t3_pre");
        ren_i  = 1'b1;
        wen_i  = 1'b0;
        addr_i = 32'h40;
        @(negedge CLK);
        chk("t3_c0", 32'(st_obs), 32'(ST_BUSY));
        @(posedge CLK); #1;
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, 2, "t3_sw");
        idle("t3_end");

        // 4: ERROR cases never touch memory
        run_txn(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 2, "t4_pre");
        run_txn(1'b1, 1'b1, 32'h8, 32'h11111111, 2, "t4_both");
        run_txn(1'b0, 1'b1, 32'h3, 32'h22222222, 2, "t4_mis");
        run_txn(1'b0, 1'b1, 32'h400, 32'h33333333, 2, "t4_oob");
        run_txn(1'b0, 1'b1, 32'h408, 32'h44444444, 2, "t4_alias");
        idle("t4_gap");
        run_txn(1'b1, 1'b0, 32'h8, 32'h0, 2, "t4_rd8");
        idle("t4_end");

        // 5: reset during a write's BUSY phase loses the write and clears memory
        ren_i   = 1'b0;
        wen_i   = 1'b1;
        addr_i  = 32'h30;
        store_i = 32'hCAFEF00D;
        @(negedge CLK);
        chk("t5_busy", 32'(st_obs), 32'(ST_BUSY));
        #2;
        nRST  = 1'b0;
        wen_i = 1'b0;
        clear_model();
        #1;
        chk("t5_inrst", 32'(st_obs), 32'(ST_FREE));
        @(posedge CLK);
        #3 nRST = 1'b1;
        @(negedge CLK);
        chk("t5_post", 32'(st_obs), 32'(ST_FREE));
        @(posedge CLK); #1;
        run_txn(1'b1, 1'b0, 32'h30, 32'h0, 2, "t5_rd30");
        run_txn(1'b1, 1'b0, 32'h20, 32'h0, 2, "t5_rd20");
        idle("t5_end");

        // 6: LAT=1 instance, back-to-back alternating write/read stream
        sel = 1'b1;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b0, 1'b1, 32'h80 + 32'(4 * (i % 3)), $urandom, 1, "t6_wr");
            run_txn(1'b1, 1'b0, 32'h80 + 32'(4 * ((i + 2) % 3)), 32'h0, 1, "t6_rd");
        end
        idle("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
